// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, rx FSM states and helpers.
// UART_RX_PARITY_EN adds the PARITY state to the rx FSM.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int SCNT_W     = $clog2(OVERSAMPLE);
  localparam int BCNT_W     = $clog2(DATA_BITS);

  typedef logic [SCNT_W-1:0] scnt_t;
  typedef logic [BCNT_W-1:0] bcnt_t;

  localparam scnt_t SAMPLE_LO   = scnt_t'(7);
  localparam scnt_t SAMPLE_MID  = scnt_t'(8);
  localparam scnt_t SAMPLE_HI   = scnt_t'(9);
  localparam scnt_t SAMPLE_LAST = scnt_t'(OVERSAMPLE - 1);
  localparam bcnt_t LAST_BIT    = bcnt_t'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick every div_i+1 clocks while enabled.
// The divisor is latched at each wrap so changes never shorten a period.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap;

  assign wrap   = en_i && (cnt_q == div_q);
  assign tick_o = wrap;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    div_d = div_q;
    if (!en_i || wrap) begin
      cnt_d = '0;
      div_d = div_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= div_i;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver, 3-sample majority vote.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames (parity_odd port).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_en,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   tick;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (rx_en),
    .div_i  (baud_div),
    .tick_o (tick)
  );

  rx_state_e            state_q, state_d;
  scnt_t                samp_q, samp_d;
  bcnt_t                bit_q, bit_d;
  logic [2:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic                 maj_win, maj_now;
  logic                 done, stop_s;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  // Stop bit is decided at count 9 using the live third sample
  assign maj_win = maj3(smp_q);
  assign maj_now = maj3({smp_q[1:0], rx_s});

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shr_d   = shr_q;
    done    = 1'b0;
    stop_s  = 1'b1;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (tick) begin
      samp_d = samp_q + 1'b1;
      if (samp_q == SAMPLE_LO || samp_q == SAMPLE_MID ||
          samp_q == SAMPLE_HI)
        smp_d = {smp_q[1:0], rx_s};
      unique case (state_q)
        RX_IDLE: begin
          samp_d = '0;
          if (!rx_s) state_d = RX_START;
        end
        RX_START: begin
          bit_d = '0;
          if (samp_q == SAMPLE_LAST)
            state_d = maj_win ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (samp_q == SAMPLE_LAST) begin
            shr_d = {maj_win, shr_q[DATA_BITS-1:1]};
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (samp_q == SAMPLE_LAST) begin
            perr_d  = maj_win ^ (^shr_q) ^ parity_odd;
            state_d = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (samp_q == SAMPLE_HI) begin
            done    = 1'b1;
            stop_s  = maj_now;
            samp_d  = '0;
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
    if (!rx_en) begin
      state_d = RX_IDLE;
      samp_d  = '0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shr_q   <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shr_q   <= shr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 phold_q, phold_d;
`endif

  // A completing frame may replace a byte being accepted this cycle
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    phold_d = phold_q;
`endif
    if (valid_q && ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || ready) begin
        data_d  = shr_q;
        ferr_d  = ~stop_s;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        phold_d = perr_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      phold_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      phold_q <= phold_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = phold_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table vectors, corner sequences and random frames
// for uart_rx_core, checked against a frame-level expectation model.
module tb_uart_rx_core;

  localparam int DIV_W = 16;
  localparam int SYNC  = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic             clk = 1'b0;
  logic             rst, rx_en, rx, ready, parity_odd;
  logic [DIV_W-1:0] baud_div;
  logic [7:0]       data;
  logic             valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_core #(
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .rx_en      (rx_en),
    .rx         (rx),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       par;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t_start, t_vrise;
  int          valid_cyc, ovr_cyc, busy_cyc;
  int          bitlen;
  rec_t        got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observer: logs accepted bytes and checks held status is stable
  logic       pv = 1'b0, pacc = 1'b0, pfe, ppe;
  logic [7:0] pd;
  always begin
    @(negedge clk);
    #1;
    if (valid === 1'b1 && pv && !pacc) begin
      checks++;
      if ({data, frame_err, parity_err} !== {pd, pfe, ppe}) begin
        errors++;
        $display("FAIL hold_stable: got %h/%b/%b expected %h/%b/%b",
                 data, frame_err, parity_err, pd, pfe, ppe);
      end
    end
    if (valid === 1'b1 && !pv) t_vrise = cyc;
    if (valid === 1'b1 && ready === 1'b1)
      got_q.push_back('{data, frame_err, parity_err});
    if (valid === 1'b1)   valid_cyc++;
    if (overrun === 1'b1) ovr_cyc++;
    if (busy === 1'b1)    busy_cyc++;
    pv   = (valid === 1'b1);
    pacc = pv && (ready === 1'b1);
    pd   = data;
    pfe  = frame_err;
    ppe  = parity_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (bitlen) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  function automatic logic exp_pe(input logic [7:0] d, input logic par,
                                  input logic odd);
`ifdef UART_RX_PARITY_EN
    return par ^ (^d) ^ odd;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_one(input string tag, input logic [7:0] ed,
                           input logic efe, input logic epe);
    rec_t r;
    chk({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      chk({tag, "_data"}, r.d, ed);
      chk({tag, "_ferr"}, r.fe, efe);
      chk({tag, "_perr"}, r.pe, epe);
    end
    got_q.delete();
  endtask

  vec_t        tbl[9];
  int unsigned lat;
  logic [7:0]  rd;
  logic        rstop, rpar;
  bit          tx_done;

  initial begin
    tbl[0] = '{8'hAA, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[3] = '{8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[4] = '{8'h03, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[8] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};

    rst = 1'b1; rx = 1'b1; rx_en = 1'b1; ready = 1'b1;
    baud_div = '0; parity_odd = 1'b0; bitlen = 16;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      got_q.delete();
      valid_cyc = 0;
      ovr_cyc   = 0;
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].par);
      check_one($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_fe,
`ifdef UART_RX_PARITY_EN
                tbl[i].exp_pe);
`else
                1'b0);
`endif
      chk($sformatf("tbl%0d_vcyc", i), valid_cyc, 1);
      chk($sformatf("tbl%0d_ovr", i), ovr_cyc, 0);
      chk($sformatf("tbl%0d_busy", i), busy, 0);
      if (i == 0) begin
        // edge -> valid: sync + 9.5 bit times (10.5 with parity)
        lat = t_vrise - t_start;
        chk("latency", (lat >= 16 * NBITS + SYNC + 9) &&
                       (lat <= 16 * NBITS + SYNC + 12), 1);
      end
    end

    got_q.delete();
    valid_cyc = 0;
    busy_cyc  = 0;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", got_q.size(), 0);
    chk("glitch_vcyc", valid_cyc, 0);
    chk("glitch_busy_seen", busy_cyc >= 1, 1);
    chk("glitch_busy_len", busy_cyc <= 17, 1);
    chk("glitch_busy_end", busy, 0);

    got_q.delete();
    ready   = 1'b0;
    ovr_cyc = 0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_pulses", ovr_cyc, 1);
    chk("ovr_data", data, 8'h11);
    chk("ovr_valid", valid, 1);
    chk("ovr_ferr", frame_err, 0);
    chk("ovr_count", got_q.size(), 0);
    ready = 1'b1;
    @(negedge clk);
    #2;
    chk("ovr_drain_valid", valid, 0);
    check_one("ovr_drain", 8'h11, 1'b0, 1'b0);
    @(negedge clk);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (bitlen / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_perr", parity_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3 * bitlen) @(negedge clk);
    got_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0);
    check_one("post_rst", 8'h3C, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      if (n % 5 == 0) begin
        rx_en    = 1'b0;
        baud_div = DIV_W'($urandom_range(0, 2));
        bitlen   = 16 * (int'(baud_div) + 1);
        @(negedge clk);
        rx_en = 1'b1;
      end
      rd         = 8'($urandom);
      rstop      = ($urandom_range(0, 3) != 0);
      rpar       = 1'($urandom);
      parity_odd = 1'($urandom);
      ovr_cyc    = 0;
      tx_done    = 1'b0;
      fork
        begin
          send_frame(rd, rstop, rpar);
          tx_done = 1'b1;
        end
        begin
          while (!tx_done) begin
            ready = 1'($urandom);
            @(negedge clk);
          end
        end
      join
      ready = 1'b1;
      for (int k = 0; k < 64 && got_q.size() == 0; k++) @(negedge clk);
      check_one($sformatf("rnd%0d", n), rd, ~rstop,
                exp_pe(rd, rpar, parity_odd));
      chk($sformatf("rnd%0d_ovr", n), ovr_cyc, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
